// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode map, datapath select codes, controller state encoding
// and the decoded EXEC control word for the accumulator CPU controller.
package cpu_ctrl_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OP_W-1:0] OP_NOR  = 4'h3;
  localparam logic [OP_W-1:0] OP_LDR  = 4'h4;
  localparam logic [OP_W-1:0] OP_STR  = 4'h5;
  localparam logic [OP_W-1:0] OP_JZR  = 4'h6;
  localparam logic [OP_W-1:0] OP_JZI  = 4'h7;
  localparam logic [OP_W-1:0] OP_JNR  = 4'h8;
  localparam logic [OP_W-1:0] OP_JNI  = 4'h9;
  localparam logic [OP_W-1:0] OP_ILL0 = 4'hA;
  localparam logic [OP_W-1:0] OP_SHL  = 4'hB;
  localparam logic [OP_W-1:0] OP_SHR  = 4'hC;
  localparam logic [OP_W-1:0] OP_LDI  = 4'hD;
  localparam logic [OP_W-1:0] OP_ILL1 = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT  = 4'hF;

  localparam logic [1:0] SEL_ACC_ALU = 2'b00;
  localparam logic [1:0] SEL_ACC_REG = 2'b01;
  localparam logic [1:0] SEL_ACC_IMM = 2'b10;

  localparam logic SEL_PC_REG = 1'b0;
  localparam logic SEL_PC_IMM = 1'b1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH      = 2'd1,
    EXEC       = 2'd2,
    HALT_STATE = 2'd3
  } state_e;

  typedef struct packed {
    logic       load_pc;
    logic       load_acc;
    logic       load_reg;
    logic       sel_pc;
    logic [1:0] sel_acc;
    logic       halt;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational EXEC-cycle decoder: opcode and ALU flags to datapath
// strobes, selects, ALU function, halt and illegal-opcode indication.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W   = 4,
  parameter int unsigned ALUOP_W = 4
) (
  input  logic [OPC_W-1:0]   opcode_i,
  input  logic               flag_z_i,
  input  logic               flag_n_i,
  output dec_t               dec_o,
  output logic [ALUOP_W-1:0] alu_op_o
);

  always_comb begin
    dec_o    = '0;
    alu_op_o = '0;
    case (opcode_i)
      OPC_W'(OP_ADD), OPC_W'(OP_SUB), OPC_W'(OP_NOR),
      OPC_W'(OP_SHL), OPC_W'(OP_SHR): begin
        alu_op_o       = ALUOP_W'(opcode_i);
        dec_o.sel_acc  = SEL_ACC_ALU;
        dec_o.load_acc = 1'b1;
      end
      OPC_W'(OP_LDR): begin
        dec_o.sel_acc  = SEL_ACC_REG;
        dec_o.load_acc = 1'b1;
      end
      OPC_W'(OP_STR): dec_o.load_reg = 1'b1;
      // Branch selects stay 0 when not taken so only live strobes toggle
      OPC_W'(OP_JZR): if (flag_z_i) begin
        dec_o.load_pc = 1'b1;
        dec_o.sel_pc  = SEL_PC_REG;
      end
      OPC_W'(OP_JZI): if (flag_z_i) begin
        dec_o.load_pc = 1'b1;
        dec_o.sel_pc  = SEL_PC_IMM;
      end
      OPC_W'(OP_JNR): if (flag_n_i) begin
        dec_o.load_pc = 1'b1;
        dec_o.sel_pc  = SEL_PC_REG;
      end
      OPC_W'(OP_JNI): if (flag_n_i) begin
        dec_o.load_pc = 1'b1;
        dec_o.sel_pc  = SEL_PC_IMM;
      end
      OPC_W'(OP_LDI): begin
        dec_o.sel_acc  = SEL_ACC_IMM;
        dec_o.load_acc = 1'b1;
      end
      OPC_W'(OP_HLT): dec_o.halt = 1'b1;
      OPC_W'(OP_ILL0), OPC_W'(OP_ILL1): dec_o.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/controller_fsm_hs.sv
// Fetch/execute sequencer for the accumulator CPU with imem handshake and
// timeout, run/single-step control, resumable halt and retired-instr count.
module controller_fsm_hs
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W         = 4,
  parameter int unsigned ALUOP_W       = 4,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               flagZ,
  input  logic               flagN,
  input  logic               run,
  input  logic               step,
  input  logic               resume,
  input  logic               imem_ack,
  output logic               imem_req,
  output logic               loadIR,
  output logic               incPC,
  output logic               loadPC,
  output logic               loadAcc,
  output logic               loadReg,
  output logic               selPC,
  output logic [1:0]         selACC,
  output logic [ALUOP_W-1:0] aluOp,
  output logic               halt,
  output logic               illegal,
  output logic               fetchErr,
  output logic [CNT_W-1:0]   instrCount
);

  localparam int unsigned TO_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;

  state_e             state_q, state_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ferr_q, ferr_d;
  dec_t               dec;
  logic [ALUOP_W-1:0] dec_alu_op;
  logic               to_hit;

  ctrl_decode #(
    .OPC_W   (OPC_W),
    .ALUOP_W (ALUOP_W)
  ) u_decode (
    .opcode_i (opcode),
    .flag_z_i (flagZ),
    .flag_n_i (flagN),
    .dec_o    (dec),
    .alu_op_o (dec_alu_op)
  );

  assign to_hit     = (FETCH_TIMEOUT != 0) && (to_cnt_q == TO_W'(FETCH_TIMEOUT - 1));
  assign fetchErr   = ferr_q;
  assign instrCount = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      to_cnt_q <= '0;
      cnt_q    <= '0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      cnt_q    <= cnt_d;
      ferr_q   <= ferr_d;
    end
  end

  // Timeout counter only advances while waiting in FETCH, so it is zero on every FETCH entry
  always_comb begin
    state_d  = state_q;
    to_cnt_d = '0;
    cnt_d    = cnt_q;
    ferr_d   = ferr_q;
    imem_req = 1'b0;
    loadIR   = 1'b0;
    incPC    = 1'b0;
    loadPC   = 1'b0;
    loadAcc  = 1'b0;
    loadReg  = 1'b0;
    selPC    = 1'b0;
    selACC   = 2'b00;
    aluOp    = '0;
    halt     = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      IDLE: begin
        if (run || step) state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          loadIR  = 1'b1;
          incPC   = 1'b1;
          state_d = EXEC;
        end else if (to_hit) begin
          ferr_d  = 1'b1;
          state_d = HALT_STATE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      EXEC: begin
        loadPC  = dec.load_pc;
        loadAcc = dec.load_acc;
        loadReg = dec.load_reg;
        selPC   = dec.sel_pc;
        selACC  = dec.sel_acc;
        aluOp   = dec_alu_op;
        halt    = dec.halt;
        illegal = dec.illegal;
        cnt_d   = cnt_q + CNT_W'(1);
        if (dec.halt)  state_d = HALT_STATE;
        else if (run)  state_d = FETCH;
        else           state_d = IDLE;
      end
      HALT_STATE: begin
        halt = 1'b1;
        if (resume) begin
          ferr_d  = 1'b0;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_controller_fsm_hs.sv
// Self-checking bench for controller_fsm_hs: directed scenarios plus a
// randomized instruction stream checked against an opcode-level model.
module tb_controller_fsm_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  opcode;
  logic        flag_z, flag_n, run, step, resume, imem_ack;

  logic        imem_req, loadIR, incPC, loadPC, loadAcc, loadReg, selPC, halt, illegal, fetchErr;
  logic [1:0]  selACC;
  logic [3:0]  aluOp;
  logic [15:0] instrCount;

  logic        imem_req_t, loadIR_t, incPC_t, loadPC_t, loadAcc_t, loadReg_t, selPC_t, halt_t, illegal_t, fetchErr_t;
  logic [1:0]  selACC_t;
  logic [3:0]  aluOp_t;
  logic [15:0] instrCount_t;

  logic [14:0] obs, obs_t;
  logic [15:0] exp_cnt;
  int          errors = 0;
  int          checks = 0;

  localparam logic [14:0] EXP_IDLE = 15'h0000;
  localparam logic [14:0] EXP_HALT = 15'h0002;

  always #5 clk = ~clk;

  controller_fsm_hs #(.OPC_W(4), .ALUOP_W(4), .CNT_W(16), .FETCH_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .flagZ(flag_z), .flagN(flag_n),
    .run(run), .step(step), .resume(resume), .imem_ack(imem_ack),
    .imem_req(imem_req), .loadIR(loadIR), .incPC(incPC), .loadPC(loadPC),
    .loadAcc(loadAcc), .loadReg(loadReg), .selPC(selPC), .selACC(selACC),
    .aluOp(aluOp), .halt(halt), .illegal(illegal), .fetchErr(fetchErr),
    .instrCount(instrCount)
  );

  controller_fsm_hs #(.OPC_W(4), .ALUOP_W(4), .CNT_W(16), .FETCH_TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .opcode(opcode), .flagZ(flag_z), .flagN(flag_n),
    .run(run), .step(step), .resume(resume), .imem_ack(imem_ack),
    .imem_req(imem_req_t), .loadIR(loadIR_t), .incPC(incPC_t), .loadPC(loadPC_t),
    .loadAcc(loadAcc_t), .loadReg(loadReg_t), .selPC(selPC_t), .selACC(selACC_t),
    .aluOp(aluOp_t), .halt(halt_t), .illegal(illegal_t), .fetchErr(fetchErr_t),
    .instrCount(instrCount_t)
  );

  // {req, loadIR, incPC, loadPC, loadAcc, loadReg, selPC, selACC[1:0], aluOp[3:0], halt, illegal}
  assign obs   = {imem_req, loadIR, incPC, loadPC, loadAcc, loadReg, selPC, selACC, aluOp, halt, illegal};
  assign obs_t = {imem_req_t, loadIR_t, incPC_t, loadPC_t, loadAcc_t, loadReg_t, selPC_t, selACC_t, aluOp_t, halt_t, illegal_t};

  function automatic logic [14:0] exp_fetch(input logic ack);
    return {1'b1, ack, ack, 12'h000};
  endfunction

  // Instruction-level meaning of each opcode expressed as the expected strobe word
  function automatic logic [14:0] ref_exec(input logic [3:0] opc, input logic z, input logic n);
    logic [14:0] e;
    logic        taken;
    e = '0;
    if (opc inside {4'd1, 4'd2, 4'd3, 4'd11, 4'd12}) begin
      e[10]  = 1'b1;
      e[5:2] = opc;
    end
    if (opc == 4'd4)  begin e[10] = 1'b1; e[7:6] = 2'd1; end
    if (opc == 4'd13) begin e[10] = 1'b1; e[7:6] = 2'd2; end
    if (opc == 4'd5)  e[9] = 1'b1;
    taken = ((opc inside {4'd6, 4'd7}) && z) || ((opc inside {4'd8, 4'd9}) && n);
    if (taken) begin
      e[11] = 1'b1;
      e[8]  = opc[0];
    end
    if (opc == 4'd15) e[1] = 1'b1;
    if (opc == 4'd10 || opc == 4'd14) e[0] = 1'b1;
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0; resume = 1'b0; imem_ack = 1'b0;
    opcode = 4'h0; flag_z = 1'b0; flag_n = 1'b0;
    cyc();
    rst = 1'b0;
    exp_cnt = '0;
    cyc();
  endtask

  // Entered at posedge+1 with the controller in FETCH; leaves one cycle after EXEC
  task automatic do_instr(input int d, input logic [3:0] opc, input logic z, input logic n, input logic r);
    checks++;
    if (instrCount !== exp_cnt) begin
      errors++;
      $display("FAIL count_pre: got %0d expected %0d", instrCount, exp_cnt);
    end
    for (int i = 0; i < d; i++) begin
      imem_ack = 1'b0;
      #1;
      checks++;
      if (obs !== exp_fetch(1'b0)) begin
        errors++;
        $display("FAIL fetch_wait[%0d]: got %h expected %h", i, obs, exp_fetch(1'b0));
      end
      cyc();
    end
    imem_ack = 1'b1;
    #1;
    checks++;
    if (obs !== exp_fetch(1'b1)) begin
      errors++;
      $display("FAIL fetch_ack: got %h expected %h", obs, exp_fetch(1'b1));
    end
    cyc();
    imem_ack = 1'b0; opcode = opc; flag_z = z; flag_n = n; run = r;
    #1;
    checks++;
    if (obs !== ref_exec(opc, z, n)) begin
      errors++;
      $display("FAIL exec op=%h z=%b n=%b: got %h expected %h", opc, z, n, obs, ref_exec(opc, z, n));
    end
    cyc();
    exp_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0; resume = 1'b0; imem_ack = 1'b0;
    opcode = 4'h0; flag_z = 1'b0; flag_n = 1'b0; exp_cnt = '0;
    #1;
    checks++;
    if ({obs, instrCount, fetchErr} !== {EXP_IDLE, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got %h/%0d/%b expected 0/0/0", obs, instrCount, fetchErr);
    end
    cyc();
    rst = 1'b0;
    cyc();
    checks++;
    if (obs !== EXP_IDLE) begin
      errors++;
      $display("FAIL reset_idle: got %h expected %h", obs, EXP_IDLE);
    end
  endtask

  task automatic test_program();
    run = 1'b1;
    #1;
    checks++;
    if (obs !== EXP_IDLE) begin
      errors++;
      $display("FAIL idle_with_run: got %h expected %h", obs, EXP_IDLE);
    end
    cyc();
    do_instr(0, 4'h1, 1'b0, 1'b0, 1'b1);
    do_instr(0, 4'hD, 1'b0, 1'b0, 1'b1);
    do_instr(0, 4'hF, 1'b0, 1'b0, 1'b1);
    run = 1'b0;
    #1;
    checks++;
    if ({obs, instrCount} !== {EXP_HALT, 16'd3}) begin
      errors++;
      $display("FAIL program_halt: got %h/%0d expected %h/3", obs, instrCount, EXP_HALT);
    end
    cyc();
  endtask

  task automatic test_branches();
    resume = 1'b1;
    #1;
    checks++;
    if (obs !== EXP_HALT) begin
      errors++;
      $display("FAIL resume_cycle: got %h expected %h", obs, EXP_HALT);
    end
    cyc();
    resume = 1'b0;
    do_instr(0, 4'h7, 1'b1, 1'b0, 1'b1);
    do_instr(1, 4'h7, 1'b0, 1'b1, 1'b1);
    do_instr(0, 4'h8, 1'b0, 1'b1, 1'b1);
    do_instr(0, 4'h8, 1'b1, 1'b0, 1'b1);
    do_instr(0, 4'h6, 1'b1, 1'b1, 1'b1);
    do_instr(0, 4'h9, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if ({obs, fetchErr} !== {EXP_IDLE, 1'b0}) begin
      errors++;
      $display("FAIL branches_idle: got %h/%b expected %h/0", obs, fetchErr, EXP_IDLE);
    end
    cyc();
  endtask

  task automatic test_ack_delay();
    run = 1'b1;
    cyc();
    do_instr(5, 4'h2, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if ({obs, fetchErr} !== {EXP_IDLE, 1'b0}) begin
      errors++;
      $display("FAIL ack_delay_end: got %h/%b expected %h/0", obs, fetchErr, EXP_IDLE);
    end
    cyc();
  endtask

  task automatic test_timeout();
    do_reset();
    run = 1'b1;
    cyc();
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b0;
      #1;
      checks++;
      if ({obs_t, fetchErr_t} !== {exp_fetch(1'b0), 1'b0}) begin
        errors++;
        $display("FAIL to_wait[%0d]: got %h/%b expected %h/0", i, obs_t, fetchErr_t, exp_fetch(1'b0));
      end
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({obs_t, fetchErr_t, instrCount_t} !== {EXP_HALT, 1'b1, 16'd0}) begin
        errors++;
        $display("FAIL to_halt[%0d]: got %h/%b/%0d expected %h/1/0", i, obs_t, fetchErr_t, instrCount_t, EXP_HALT);
      end
      cyc();
    end
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    #1;
    checks++;
    if ({obs_t, fetchErr_t} !== {exp_fetch(1'b0), 1'b0}) begin
      errors++;
      $display("FAIL to_resume: got %h/%b expected %h/0", obs_t, fetchErr_t, exp_fetch(1'b0));
    end
    imem_ack = 1'b1;
    #1;
    checks++;
    if (obs_t !== exp_fetch(1'b1)) begin
      errors++;
      $display("FAIL to_refetch: got %h expected %h", obs_t, exp_fetch(1'b1));
    end
    cyc();
    imem_ack = 1'b0;
    opcode = 4'h0;
    cyc();
    checks++;
    if ({obs_t, instrCount_t} !== {EXP_IDLE, 16'd1}) begin
      errors++;
      $display("FAIL to_after_nop: got %h/%0d expected %h/1", obs_t, instrCount_t, EXP_IDLE);
    end
  endtask

  task automatic test_step();
    do_reset();
    step = 1'b1;
    #1;
    checks++;
    if (obs !== EXP_IDLE) begin
      errors++;
      $display("FAIL step_idle: got %h expected %h", obs, EXP_IDLE);
    end
    cyc();
    step = 1'b0;
    do_instr(2, 4'h4, 1'b0, 1'b0, 1'b0);
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    cyc();
    checks++;
    if (obs !== EXP_IDLE) begin
      errors++;
      $display("FAIL step_between: got %h expected %h", obs, EXP_IDLE);
    end
    step = 1'b1;
    cyc();
    step = 1'b0;
    do_instr(0, 4'hA, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if ({obs, instrCount} !== {EXP_IDLE, 16'd2}) begin
      errors++;
      $display("FAIL step_count: got %h/%0d expected %h/2", obs, instrCount, EXP_IDLE);
    end
    cyc();
  endtask

  task automatic test_reset_mid_fetch();
    run = 1'b1;
    cyc();
    do_instr(0, 4'h5, 1'b0, 1'b0, 1'b1);
    run = 1'b0;
    imem_ack = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({obs, instrCount} !== {EXP_IDLE, 16'd0}) begin
      errors++;
      $display("FAIL rst_mid_fetch: got %h/%0d expected %h/0", obs, instrCount, EXP_IDLE);
    end
    imem_ack = 1'b1;
    cyc();
    rst = 1'b0;
    exp_cnt = '0;
    cyc();
    checks++;
    if (obs !== EXP_IDLE) begin
      errors++;
      $display("FAIL rst_late_ack: got %h expected %h", obs, EXP_IDLE);
    end
    imem_ack = 1'b0;
    run = 1'b1;
    cyc();
    do_instr(1, 4'h3, 1'b0, 1'b0, 1'b0);
    cyc();
  endtask

  task automatic test_random();
    int          d;
    logic [3:0]  opc;
    logic        z, n, r;
    do_reset();
    run = 1'b1;
    cyc();
    for (int k = 0; k < 60; k++) begin
      d   = int'($urandom_range(0, 6));
      opc = 4'($urandom_range(0, 15));
      z   = 1'($urandom_range(0, 1));
      n   = 1'($urandom_range(0, 1));
      r   = ($urandom_range(0, 3) != 0);
      do_instr(d, opc, z, n, r);
      if (opc == 4'hF) begin
        #1;
        checks++;
        if (obs !== EXP_HALT) begin
          errors++;
          $display("FAIL rnd_halt[%0d]: got %h expected %h", k, obs, EXP_HALT);
        end
        resume = 1'b1;
        cyc();
        resume = 1'b0;
      end else if (!r) begin
        #1;
        checks++;
        if (obs !== EXP_IDLE) begin
          errors++;
          $display("FAIL rnd_idle[%0d]: got %h expected %h", k, obs, EXP_IDLE);
        end
        if ($urandom_range(0, 1) != 0) step = 1'b1;
        else run = 1'b1;
        cyc();
        step = 1'b0;
      end
    end
    checks++;
    if ({instrCount, fetchErr} !== {exp_cnt, 1'b0}) begin
      errors++;
      $display("FAIL rnd_count: got %0d/%b expected %0d/0", instrCount, fetchErr, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_branches();
    test_ack_delay();
    test_timeout();
    test_step();
    test_reset_mid_fetch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
